// File: rtl/melody_pkg.sv
// melody_pkg: pitch codes, base note frequencies, sequence entry layout and FSM states
package melody_pkg;

    localparam logic [3:0] PITCH_REST = 4'd0;
    localparam logic [3:0] PITCH_END  = 4'd15;

    // C4 D4 E4 F4 G4 A4 B4 in Hz
    localparam int unsigned BASE_HZ [7] = '{262, 294, 330, 349, 392, 440, 494};

    typedef struct packed {
        logic [3:0]  pitch;
        logic [11:0] dur;
    } entry_t;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_PLAY, S_GAP} state_t;

endpackage

// File: rtl/melody_tick_gen.sv
// melody_tick_gen: duration prescaler, one-cycle tick every len cycles, restartable
module melody_tick_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic [31:0] len,
    output logic        tick
);

    logic [31:0] cnt;

    assign tick = (cnt + 32'd1) >= len;

    // count up, wrap on tick, zero on restart so every interval starts fresh
    always_ff @(posedge clk) begin
        if (reset || restart)
            cnt <= '0;
        else
            cnt <= tick ? '0 : cnt + 32'd1;
    end

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a writable {pitch, duration} table as half_period/note_enable.
// Optional TEMPO_CTRL_EN adds tempo_shift[1:0] shortening the duration tick.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int CLK_FREQ  = 25000000,
    parameter int NUM_NOTES = 16,
    parameter int TICK_DIV  = 25000,
    parameter int GAP_TICKS = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_NOTES)-1:0] wr_addr,
    input  logic [15:0]                  wr_data,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop_en,
`ifdef TEMPO_CTRL_EN
    input  logic [1:0]                   tempo_shift,
`endif
    output logic                         note_enable,
    output logic [31:0]                  half_period,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_NOTES)-1:0] cur_index
);

    localparam logic [31:0] HP [8] = '{
        32'(CLK_FREQ / (2 * BASE_HZ[0])), 32'(CLK_FREQ / (2 * BASE_HZ[1])),
        32'(CLK_FREQ / (2 * BASE_HZ[2])), 32'(CLK_FREQ / (2 * BASE_HZ[3])),
        32'(CLK_FREQ / (2 * BASE_HZ[4])), 32'(CLK_FREQ / (2 * BASE_HZ[5])),
        32'(CLK_FREQ / (2 * BASE_HZ[6])), 32'd0
    };

    entry_t                         ram [NUM_NOTES];
    entry_t                         ent;
    state_t                         state, nxt;
    logic [$clog2(NUM_NOTES)-1:0]   idx_nxt;
    logic [11:0]                    ticks;
    logic [31:0]                    tick_len, hp_dec;
    logic [2:0]                     note_idx;
    logic                           start_q, tick, restart, fin, adv, ending;

    assign busy     = state != S_IDLE;
    assign restart  = nxt != state;
    assign note_idx = ent.pitch[3] ? ent.pitch[2:0] : ent.pitch[2:0] - 3'd1;
    assign hp_dec   = ent.pitch[3] ? HP[note_idx] >> 1 : HP[note_idx];

`ifdef TEMPO_CTRL_EN
    logic [1:0] shift_q;
    // tempo is frozen per entry at decode
    always_ff @(posedge clk) begin
        if (reset)
            shift_q <= 2'd0;
        else if (state == S_DECODE)
            shift_q <= tempo_shift;
    end
    assign tick_len = 32'(TICK_DIV) >> shift_q;
`else
    assign tick_len = 32'(TICK_DIV);
`endif

    melody_tick_gen u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .len     (tick_len),
        .tick    (tick)
    );

    // sequence RAM; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en)
            ram[wr_addr] <= entry_t'(wr_data);
    end

    // next state: playback walk, end handling, stop overrides everything
    always_comb begin
        nxt     = state;
        idx_nxt = cur_index;
        fin     = 1'b0;
        adv     = 1'b0;
        ending  = 1'b0;
        case (state)
            S_IDLE:   if (start_q) begin
                          nxt     = S_FETCH;
                          idx_nxt = '0;
                      end
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: if (ent.pitch == PITCH_END)
                          ending = 1'b1;
                      else if (ent.dur == 12'd0)
                          adv = 1'b1;
                      else
                          nxt = S_PLAY;
            S_PLAY:   if (tick && ticks == ent.dur - 12'd1) begin
                          if (GAP_TICKS == 0)
                              adv = 1'b1;
                          else
                              nxt = S_GAP;
                      end
            S_GAP:    adv = tick && ticks == 12'(GAP_TICKS - 1);
            default:  nxt = S_IDLE;
        endcase
        if (adv) begin
            if (&cur_index)
                ending = 1'b1;
            else begin
                nxt     = S_FETCH;
                idx_nxt = cur_index + 1'b1;
            end
        end
        if (ending) begin
            nxt     = loop_en ? S_FETCH : S_IDLE;
            idx_nxt = loop_en ? '0 : cur_index;
            fin     = !loop_en;
        end
        if (stop) begin
            nxt = S_IDLE;
            fin = 1'b0;
        end
    end

    // state, registered start request, entry fetch and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cur_index   <= '0;
            ent         <= '0;
            ticks       <= '0;
            start_q     <= 1'b0;
            note_enable <= 1'b0;
            half_period <= '0;
            done        <= 1'b0;
        end else begin
            state       <= nxt;
            cur_index   <= idx_nxt;
            done        <= fin;
            start_q     <= start && !stop && state == S_IDLE && !start_q;
            ticks       <= restart ? '0 : ticks + 12'(tick);
            note_enable <= nxt == S_PLAY && ent.pitch != PITCH_REST;
            if (state == S_FETCH)
                ent <= ram[cur_index];
            if (state == S_DECODE && nxt == S_PLAY && ent.pitch != PITCH_REST)
                half_period <= hp_dec;
        end
    end

endmodule
